// File: rtl/lotr_pkg.sv
// lotr_pkg -- shared types and constants for the LOTR ring/core blocks.
//   t_opcode      : ring request opcode
//   I_MEM_REGION  : address region decoded from addr[MSB_REGION:LSB_REGION]
//   MSB_I_MEM     : top byte-address bit of the instruction memory
//   t_imem_owner  : who owns the memory read data returning next cycle
//   t_imem_req    : one buffered ring request (opcode, word address, data)
package lotr_pkg;

    typedef enum logic [1:0] {
        RD     = 2'b00,
        RD_RSP = 2'b01,
        WR     = 2'b10,
        WR_RSP = 2'b11
    } t_opcode;

    localparam int MSB_REGION = 31;
    localparam int LSB_REGION = 28;
    localparam logic [MSB_REGION-LSB_REGION:0] I_MEM_REGION = 4'h1;
    localparam int MSB_I_MEM = 12;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        CORE = 2'b01,
        RING = 2'b10
    } t_imem_owner;

    typedef struct packed {
        t_opcode               opcode;
        logic [MSB_I_MEM:2]    addr;
        logic [31:0]           data;
    } t_imem_req;

endpackage

// File: rtl/i_mem_req_fifo.sv
// i_mem_req_fifo -- small request buffer with wrapping pointers and an
// occupancy counter.
//   QClk, RstQnnnL : clock, asynchronous active-low reset
//   Push, WrData   : write an entry (ignored when Full)
//   Pop, RdData    : drop the head entry (ignored when Empty); RdData is the head
//   Count          : number of valid entries
//   Full, Empty    : occupancy flags
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module i_mem_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                     QClk,
    input  logic                     RstQnnnL,
    input  logic                     Push,
    input  logic                     Pop,
    input  logic [WIDTH-1:0]         WrData,
    output logic [WIDTH-1:0]         RdData,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Full,
    output logic                     Empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] entries [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign Full   = (Count == (PTR_W+1)'(DEPTH));
    assign Empty  = (Count == '0);
    // A push on the full cycle is dropped; a pop that cycle still goes ahead.
    assign doPush = Push && !Full;
    assign doPop  = Pop && !Empty;
    assign RdData = entries[rdPtr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge QClk) begin
        if (doPush) begin
            entries[wrPtr] <= WrData;
        end
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            wrPtr <= '0;
            rdPtr <= '0;
            Count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   Count <= Count + 1'b1;
                2'b01:   Count <= Count - 1'b1;
                default: Count <= Count;
            endcase
        end
    end

endmodule

// File: rtl/i_mem_arb.sv
// i_mem_arb -- arbitrates the single-port instruction memory between the
// core fetch port and buffered ring requests.
//   QClk, RstQnnnL       : clock, asynchronous active-low reset
//   PcQ100H/RdEnable...  : core fetch request; FetchGntQ100H is combinational
//   InstFetch/InstValid  : fetch data, one cycle after the grant
//   F2C_Req*Q503H        : ring request in; ready = buffer not full
//   F2C_RspIMem*Q504H    : ring read response, one cycle after the grant
//   Mem*Q500H/Q501H      : memory port, one-cycle read latency
// Handshake: a ring request transfers on a clock edge where valid and ready
// are both high; requests outside the I_MEM region or with a response opcode
// are dropped silently.
module i_mem_arb
    import lotr_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                 QClk,
    input  logic                 RstQnnnL,
    input  logic [31:0]          PcQ100H,
    input  logic                 RdEnableQ100H,
    output logic                 FetchGntQ100H,
    output logic [31:0]          InstFetchQ101H,
    output logic                 InstValidQ101H,
    input  logic                 F2C_ReqValidQ503H,
    input  t_opcode              F2C_ReqOpcodeQ503H,
    input  logic [31:0]          F2C_ReqAddressQ503H,
    input  logic [31:0]          F2C_ReqDataQ503H,
    output logic                 F2C_ReqReadyQ503H,
    output logic                 F2C_RspIMemValidQ504H,
    output logic [31:0]          F2C_I_MemRspDataQ504H,
    output logic [MSB_I_MEM:2]   MemAddrQ500H,
    output logic [31:0]          MemWrDataQ500H,
    output logic                 MemRdEnQ500H,
    output logic                 MemWrEnQ500H,
    input  logic [31:0]          MemRdDataQ501H
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    t_imem_req                   pushReq;
    t_imem_req                   headReq;
    logic [$clog2(FIFO_DEPTH):0] fifoCount;
    logic                        fifoFull;
    logic                        fifoEmpty;
    logic                        regionHit;
    logic                        opcodeOk;
    logic                        pushEn;
    logic                        starveHit;
    logic                        coreGnt;
    logic                        ringGnt;
    logic [STARVE_W-1:0]         starveCnt;
    t_imem_owner                 owner;
    logic                        unusedBits;

    assign regionHit = (F2C_ReqAddressQ503H[MSB_REGION:LSB_REGION] == I_MEM_REGION);
    assign opcodeOk  = (F2C_ReqOpcodeQ503H == RD) || (F2C_ReqOpcodeQ503H == WR);
    assign pushEn    = F2C_ReqValidQ503H && F2C_ReqReadyQ503H && regionHit && opcodeOk;

    always_comb begin
        pushReq        = '0;
        pushReq.opcode = F2C_ReqOpcodeQ503H;
        pushReq.addr   = F2C_ReqAddressQ503H[MSB_I_MEM:2];
        pushReq.data   = F2C_ReqDataQ503H;
    end

    i_mem_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(t_imem_req))
    ) uReqFifo (
        .QClk     (QClk),
        .RstQnnnL (RstQnnnL),
        .Push     (pushEn),
        .Pop      (ringGnt),
        .WrData   (pushReq),
        .RdData   (headReq),
        .Count    (fifoCount),
        .Full     (fifoFull),
        .Empty    (fifoEmpty)
    );

    // Count is read here only through Full/Empty.
    assign unusedBits = &{1'b0, fifoCount, PcQ100H[31:MSB_I_MEM+1], PcQ100H[1:0],
                          F2C_ReqAddressQ503H[LSB_REGION-1:MSB_I_MEM+1],
                          F2C_ReqAddressQ503H[1:0]};

    assign F2C_ReqReadyQ503H = !fifoFull;

    // Starved core beats the ring; otherwise buffered ring work goes first.
    // Grants are gated by reset so every memory-side output is 0 in reset.
    assign starveHit = (starveCnt == STARVE_W'(STARVE_MAX));
    assign coreGnt   = RstQnnnL && RdEnableQ100H && (starveHit || fifoEmpty);
    assign ringGnt   = RstQnnnL && !fifoEmpty && !coreGnt;

    always_comb begin
        FetchGntQ100H  = coreGnt;
        MemAddrQ500H   = '0;
        MemWrDataQ500H = '0;
        MemRdEnQ500H   = 1'b0;
        MemWrEnQ500H   = 1'b0;
        if (coreGnt) begin
            MemAddrQ500H = PcQ100H[MSB_I_MEM:2];
            MemRdEnQ500H = 1'b1;
        end else if (ringGnt) begin
            MemAddrQ500H = headReq.addr;
            if (headReq.opcode == WR) begin
                MemWrEnQ500H   = 1'b1;
                MemWrDataQ500H = headReq.data;
            end else begin
                MemRdEnQ500H = 1'b1;
            end
        end
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            starveCnt <= '0;
            owner     <= NONE;
        end else begin
            if (!RdEnableQ100H || coreGnt) begin
                starveCnt <= '0;
            end else if (!starveHit) begin
                starveCnt <= starveCnt + 1'b1;
            end

            // Ring writes have no response, so they leave the owner at NONE.
            if (coreGnt) begin
                owner <= CORE;
            end else if (ringGnt && (headReq.opcode == RD)) begin
                owner <= RING;
            end else begin
                owner <= NONE;
            end
        end
    end

    assign InstValidQ101H        = (owner == CORE);
    assign InstFetchQ101H        = InstValidQ101H ? MemRdDataQ501H : '0;
    assign F2C_RspIMemValidQ504H = (owner == RING);
    assign F2C_I_MemRspDataQ504H = F2C_RspIMemValidQ504H ? MemRdDataQ501H : '0;

endmodule

// File: tb/tb_i_mem_arb.sv
module tb_i_mem_arb;
    import lotr_pkg::*;

    localparam int FIFO_DEPTH = 2;
    localparam int STARVE_MAX = 4;

    logic               QClk;
    logic               RstQnnnL;
    logic [31:0]        PcQ100H;
    logic               RdEnableQ100H;
    logic               FetchGntQ100H;
    logic [31:0]        InstFetchQ101H;
    logic               InstValidQ101H;
    logic               F2C_ReqValidQ503H;
    t_opcode            F2C_ReqOpcodeQ503H;
    logic [31:0]        F2C_ReqAddressQ503H;
    logic [31:0]        F2C_ReqDataQ503H;
    logic               F2C_ReqReadyQ503H;
    logic               F2C_RspIMemValidQ504H;
    logic [31:0]        F2C_I_MemRspDataQ504H;
    logic [MSB_I_MEM:2] MemAddrQ500H;
    logic [31:0]        MemWrDataQ500H;
    logic               MemRdEnQ500H;
    logic               MemWrEnQ500H;
    logic [31:0]        MemRdDataQ501H = '0;

    int checks = 0;
    int errors = 0;

    i_mem_arb #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .QClk                  (QClk),
        .RstQnnnL              (RstQnnnL),
        .PcQ100H               (PcQ100H),
        .RdEnableQ100H         (RdEnableQ100H),
        .FetchGntQ100H         (FetchGntQ100H),
        .InstFetchQ101H        (InstFetchQ101H),
        .InstValidQ101H        (InstValidQ101H),
        .F2C_ReqValidQ503H     (F2C_ReqValidQ503H),
        .F2C_ReqOpcodeQ503H    (F2C_ReqOpcodeQ503H),
        .F2C_ReqAddressQ503H   (F2C_ReqAddressQ503H),
        .F2C_ReqDataQ503H      (F2C_ReqDataQ503H),
        .F2C_ReqReadyQ503H     (F2C_ReqReadyQ503H),
        .F2C_RspIMemValidQ504H (F2C_RspIMemValidQ504H),
        .F2C_I_MemRspDataQ504H (F2C_I_MemRspDataQ504H),
        .MemAddrQ500H          (MemAddrQ500H),
        .MemWrDataQ500H        (MemWrDataQ500H),
        .MemRdEnQ500H          (MemRdEnQ500H),
        .MemWrEnQ500H          (MemWrEnQ500H),
        .MemRdDataQ501H        (MemRdDataQ501H)
    );

    // clock / reset block
    initial QClk = 1'b0;
    always #5 QClk = ~QClk;

    // memory model: word i initially holds 0xA000_0000 + i
    logic [31:0] mem [0:2047];
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] <= 32'hA000_0000 + i;
    end
    always @(posedge QClk) begin
        if (MemWrEnQ500H) mem[MemAddrQ500H] <= MemWrDataQ500H;
        if (MemRdEnQ500H) MemRdDataQ501H <= mem[MemAddrQ500H];
    end

    typedef struct {
        logic        rdEn;
        logic [31:0] pc;
        logic        reqV;
        t_opcode     opc;
        logic [31:0] addr;
        logic [31:0] data;
        logic        gnt;
        logic        memRd;
        logic        memWr;
        logic [31:0] memAddr;
        logic [31:0] memWrData;
        logic        ready;
        logic        instV;
        logic [31:0] inst;
        logic        rspV;
        logic [31:0] rspData;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge QClk);
        #1;
    endtask

    task automatic drive(input logic rdEn, input logic [31:0] pc, input logic reqV,
                         input t_opcode opc, input logic [31:0] addr, input logic [31:0] data);
        RdEnableQ100H       = rdEn;
        PcQ100H             = pc;
        F2C_ReqValidQ503H   = reqV;
        F2C_ReqOpcodeQ503H  = opc;
        F2C_ReqAddressQ503H = addr;
        F2C_ReqDataQ503H    = data;
    endtask

    task automatic idleIn();
        drive(1'b0, 32'h0, 1'b0, RD, 32'h0, 32'h0);
    endtask

    task automatic chkResetOutputs(input string tag);
        chk({tag, "_gnt"},     32'(FetchGntQ100H), 32'h0);
        chk({tag, "_memrd"},   32'(MemRdEnQ500H), 32'h0);
        chk({tag, "_memwr"},   32'(MemWrEnQ500H), 32'h0);
        chk({tag, "_memaddr"}, 32'(MemAddrQ500H), 32'h0);
        chk({tag, "_wrdata"},  MemWrDataQ500H, 32'h0);
        chk({tag, "_instv"},   32'(InstValidQ101H), 32'h0);
        chk({tag, "_inst"},    InstFetchQ101H, 32'h0);
        chk({tag, "_rspv"},    32'(F2C_RspIMemValidQ504H), 32'h0);
        chk({tag, "_rspdata"}, F2C_I_MemRspDataQ504H, 32'h0);
        chk({tag, "_ready"},   32'(F2C_ReqReadyQ503H), 32'h1);
    endtask

    // Core requests every cycle while the ring streams 7 requests with
    // valid/ready. Expected: core grant at k0 (empty FIFO) and k5 (starved
    // after 4 denials); ready drops at k6 when both entries are occupied.
    task automatic contention(input t_opcode opc, input logic [31:0] base, input logic doReset);
        logic [7:0]         expGnt   = 8'b0010_0001;
        logic [7:0]         expReady = 8'b1011_1111;
        logic [MSB_I_MEM:2] word0;
        int                 w = 0;
        word0 = base[MSB_I_MEM:2];
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'h0000_0300, (w < 7), opc, base + 32'(4 * w), 32'hC0DE_0000 + 32'(w));
            if (doReset && k == 7) begin
                // ring read granted at k6 is in flight; one entry still buffered
                RstQnnnL = 1'b0;
                @(negedge QClk);
                chkResetOutputs("midrst");
                nextCycle();
                RstQnnnL = 1'b1;
                idleIn();
                @(negedge QClk);
                chk("midrst_count", 32'(dut.uReqFifo.Count), 32'h0);
                chk("midrst_ready_after", 32'(F2C_ReqReadyQ503H), 32'h1);
                for (int j = 0; j < 3; j++) begin
                    chk("midrst_no_rd", 32'(MemRdEnQ500H), 32'h0);
                    chk("midrst_no_rsp", 32'(F2C_RspIMemValidQ504H), 32'h0);
                    nextCycle();
                    @(negedge QClk);
                end
                nextCycle();
                return;
            end
            @(negedge QClk);
            chk($sformatf("cont_gnt_k%0d", k), 32'(FetchGntQ100H), 32'(expGnt[k]));
            chk($sformatf("cont_ready_k%0d", k), 32'(F2C_ReqReadyQ503H), 32'(expReady[k]));
            if (opc == WR)
                chk($sformatf("cont_wren_k%0d", k), 32'(MemWrEnQ500H), 32'(!expGnt[k]));
            if (k == 6)
                chk("cont_starve_cleared", 32'(dut.starveCnt), 32'h0);
            if (F2C_ReqValidQ503H && F2C_ReqReadyQ503H) w++;
            nextCycle();
        end
        idleIn();
        repeat (4) nextCycle();
        chk("cont_all_accepted", 32'(w), 32'd7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("cont_mem_w%0d", i), mem[word0 + 11'(i)], 32'hC0DE_0000 + 32'(i));
    endtask

    initial begin
        RstQnnnL = 1'b0;
        idleIn();
        repeat (2) @(posedge QClk);
        @(negedge QClk);
        chkResetOutputs("rst");
        // reset still asserted with requests present: outputs must stay quiet
        drive(1'b1, 32'h10, 1'b1, RD, 32'h1000_0020, 32'h0);
        #1;
        chkResetOutputs("rst_req");
        idleIn();
        nextCycle();
        RstQnnnL = 1'b1;

        //           rdEn pc            v   opc     addr           data          | gnt rd wr addr wrdata        rdy iv inst           rv rsp
        vecs.push_back('{1'b0, 32'h0,  1'b0, RD,     32'h0,         32'h0,         1'b0,1'b0,1'b0,32'd0, 32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0});
        vecs.push_back('{1'b1, 32'h10, 1'b0, RD,     32'h0,         32'h0,         1'b1,1'b1,1'b0,32'd4, 32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0});
        vecs.push_back('{1'b0, 32'h0,  1'b0, RD,     32'h0,         32'h0,         1'b0,1'b0,1'b0,32'd0, 32'h0,        1'b1,1'b1,32'hA0000004, 1'b0,32'h0});
        vecs.push_back('{1'b0, 32'h0,  1'b1, RD,     32'h1000_0020, 32'h0,         1'b0,1'b0,1'b0,32'd0, 32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0});
        vecs.push_back('{1'b0, 32'h0,  1'b0, RD,     32'h0,         32'h0,         1'b0,1'b1,1'b0,32'd8, 32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0});
        vecs.push_back('{1'b0, 32'h0,  1'b0, RD,     32'h0,         32'h0,         1'b0,1'b0,1'b0,32'd0, 32'h0,        1'b1,1'b0,32'h0,        1'b1,32'hA0000008});
        vecs.push_back('{1'b0, 32'h0,  1'b1, WR,     32'h1000_0040, 32'hDEADBEEF,  1'b0,1'b0,1'b0,32'd0, 32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0});
        vecs.push_back('{1'b0, 32'h0,  1'b0, RD,     32'h0,         32'h0,         1'b0,1'b0,1'b1,32'd16,32'hDEADBEEF, 1'b1,1'b0,32'h0,        1'b0,32'h0});
        vecs.push_back('{1'b0, 32'h0,  1'b1, RD,     32'h1000_0040, 32'h0,         1'b0,1'b0,1'b0,32'd0, 32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0});
        vecs.push_back('{1'b0, 32'h0,  1'b0, RD,     32'h0,         32'h0,         1'b0,1'b1,1'b0,32'd16,32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0});
        vecs.push_back('{1'b0, 32'h0,  1'b0, RD,     32'h0,         32'h0,         1'b0,1'b0,1'b0,32'd0, 32'h0,        1'b1,1'b0,32'h0,        1'b1,32'hDEADBEEF});
        vecs.push_back('{1'b0, 32'h0,  1'b1, RD,     32'h2000_0020, 32'h0,         1'b0,1'b0,1'b0,32'd0, 32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0});
        vecs.push_back('{1'b0, 32'h0,  1'b0, RD,     32'h0,         32'h0,         1'b0,1'b0,1'b0,32'd0, 32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0});
        vecs.push_back('{1'b0, 32'h0,  1'b0, RD,     32'h0,         32'h0,         1'b0,1'b0,1'b0,32'd0, 32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0});
        vecs.push_back('{1'b0, 32'h0,  1'b1, RD_RSP, 32'h1000_0020, 32'h0,         1'b0,1'b0,1'b0,32'd0, 32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0});
        vecs.push_back('{1'b0, 32'h0,  1'b0, RD,     32'h0,         32'h0,         1'b0,1'b0,1'b0,32'd0, 32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0});
        vecs.push_back('{1'b1, 32'h20, 1'b1, RD,     32'h1000_0020, 32'h0,         1'b1,1'b1,1'b0,32'd8, 32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0});
        vecs.push_back('{1'b1, 32'h24, 1'b0, RD,     32'h0,         32'h0,         1'b0,1'b1,1'b0,32'd8, 32'h0,        1'b1,1'b1,32'hA0000008, 1'b0,32'h0});
        vecs.push_back('{1'b1, 32'h24, 1'b0, RD,     32'h0,         32'h0,         1'b1,1'b1,1'b0,32'd9, 32'h0,        1'b1,1'b0,32'h0,        1'b1,32'hA0000008});
        vecs.push_back('{1'b0, 32'h0,  1'b0, RD,     32'h0,         32'h0,         1'b0,1'b0,1'b0,32'd0, 32'h0,        1'b1,1'b1,32'hA0000009, 1'b0,32'h0});

        foreach (vecs[i]) begin
            drive(vecs[i].rdEn, vecs[i].pc, vecs[i].reqV, vecs[i].opc, vecs[i].addr, vecs[i].data);
            @(negedge QClk);
            chk($sformatf("v%0d_gnt", i),     32'(FetchGntQ100H),          32'(vecs[i].gnt));
            chk($sformatf("v%0d_memrd", i),   32'(MemRdEnQ500H),           32'(vecs[i].memRd));
            chk($sformatf("v%0d_memwr", i),   32'(MemWrEnQ500H),           32'(vecs[i].memWr));
            chk($sformatf("v%0d_memaddr", i), 32'(MemAddrQ500H),           vecs[i].memAddr);
            chk($sformatf("v%0d_wrdata", i),  MemWrDataQ500H,              vecs[i].memWrData);
            chk($sformatf("v%0d_ready", i),   32'(F2C_ReqReadyQ503H),      32'(vecs[i].ready));
            chk($sformatf("v%0d_instv", i),   32'(InstValidQ101H),         32'(vecs[i].instV));
            chk($sformatf("v%0d_inst", i),    InstFetchQ101H,              vecs[i].inst);
            chk($sformatf("v%0d_rspv", i),    32'(F2C_RspIMemValidQ504H),  32'(vecs[i].rspV));
            chk($sformatf("v%0d_rspdata", i), F2C_I_MemRspDataQ504H,       vecs[i].rspData);
            nextCycle();
        end
        idleIn();
        repeat (2) nextCycle();

        contention(WR, 32'h1000_0200, 1'b0);
        contention(RD, 32'h1000_0400, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
